// File: rtl/brc_serial.sv
// Serial MSB-first branch comparator: compares two operands CHUNK_W bits per cycle
// and resolves less/equal flags plus the taken bit for a RISC-V branch funct3.
module brc_serial #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CHUNK_W    = 8,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_br_uns,
  input  logic [2:0]        i_br_cond,
  input  logic [DATA_W-1:0] i_operand_a,
  input  logic [DATA_W-1:0] i_operand_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_br_less,
  output logic              o_br_equal,
  output logic              o_br_taken
);

  localparam int unsigned NCHUNK = DATA_W / CHUNK_W;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [DATA_W-1:0] MSB_MASK = DATA_W'(1) << (DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [DATA_W-1:0]  a_q, b_q;
  logic [2:0]         cond_q;
  logic [IDX_W-1:0]   idx_q;
  logic               decided_q, verdict_q;
  logic               ready_q, valid_q, less_q, equal_q, taken_q;

  logic [CHUNK_W-1:0] chunk_a_c, chunk_b_c;
  logic               diff_c, decided_c, verdict_c, last_c, finish_c;
  logic               less_fin_c, equal_fin_c;

  function automatic logic taken_f(input logic [2:0] cond, input logic eq, input logic lt);
    case (cond)
      3'b000:         taken_f = eq;
      3'b001:         taken_f = ~eq;
      3'b100, 3'b110: taken_f = lt;
      3'b101, 3'b111: taken_f = ~lt;
      default:        taken_f = 1'b0;
    endcase
  endfunction

  // Operands shift left each BUSY cycle so the chunk under test is always at the top.
  always_comb begin
    chunk_a_c   = a_q[DATA_W-1 -: CHUNK_W];
    chunk_b_c   = b_q[DATA_W-1 -: CHUNK_W];
    diff_c      = (chunk_a_c != chunk_b_c);
    decided_c   = decided_q | diff_c;
    verdict_c   = decided_q ? verdict_q : (chunk_a_c < chunk_b_c);
    last_c      = (idx_q == IDX_W'(NCHUNK - 1));
    finish_c    = last_c || (EARLY_EXIT && diff_c && !decided_q);
    less_fin_c  = decided_c & verdict_c;
    equal_fin_c = ~decided_c;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
      taken_q   <= 1'b0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      verdict_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cond_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            // Flipping the sign bit maps two's-complement order onto unsigned order.
            a_q       <= i_operand_a ^ (i_br_uns ? '0 : MSB_MASK);
            b_q       <= i_operand_b ^ (i_br_uns ? '0 : MSB_MASK);
            cond_q    <= i_br_cond;
            idx_q     <= '0;
            decided_q <= 1'b0;
            verdict_q <= 1'b0;
            ready_q   <= 1'b0;
            state_q   <= S_BUSY;
          end
        end
        S_BUSY: begin
          a_q       <= a_q << CHUNK_W;
          b_q       <= b_q << CHUNK_W;
          idx_q     <= idx_q + 1'b1;
          decided_q <= decided_c;
          verdict_q <= verdict_c;
          if (finish_c) begin
            less_q  <= less_fin_c;
            equal_q <= equal_fin_c;
            taken_q <= taken_f(cond_q, equal_fin_c, less_fin_c);
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_br_less  = less_q;
  assign o_br_equal = equal_q;
  assign o_br_taken = taken_q;

endmodule
